// File: rtl/csr_fifo_window_pkg.sv
// Shared types and default constants for the CSR FIFO data-port window.
package csr_fifo_window_pkg;

  localparam int unsigned CSR_ADDR_W   = 12;
  localparam int unsigned CSR_DATA_W   = 32;
  localparam logic [CSR_ADDR_W-1:0] TX_PORT_ADDR_DEFAULT = 12'h0C8;
  localparam logic [CSR_ADDR_W-1:0] RX_PORT_ADDR_DEFAULT = 12'h0CC;

  // Window FSM states; exported on the debug port of the top.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_WAIT = 3'd1,
    RX_WAIT = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  // Registered read response produced by the window FSM.
  typedef struct packed {
    logic                  ack;
    logic                  err;
    logic [CSR_DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/csr_fifo_window_wait_timer.sv
// Cycle counter bounding how long the window waits for a queue handshake.
module wait_timer #(
  parameter int unsigned StallTimeout = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (StallTimeout > 2) ? $clog2(StallTimeout) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(StallTimeout - 1);

  logic [CntW-1:0] cnt_q;

  // Clear has priority; otherwise count while enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = en_i && (cnt_q == TcVal);

endmodule

// File: rtl/csr_fifo_window.sv
// Maps TX/RX data-port addresses onto valid/ready queues; all other CSR
// traffic passes straight through to the generated CSR block.
//
// Handshake rule (both queues): a transfer happens on a cycle where valid and
// ready are both high at the rising clock edge; the valid side holds valid
// and data stable until that edge, and neither side may wait on the other.
module csr_fifo_window
  import csr_fifo_window_pkg::*;
#(
  parameter int unsigned           CsrAddrWidth = CSR_ADDR_W,
  parameter int unsigned           CsrDataWidth = CSR_DATA_W,
  parameter logic [CsrAddrWidth-1:0] TxPortAddr = TX_PORT_ADDR_DEFAULT,
  parameter logic [CsrAddrWidth-1:0] RxPortAddr = RX_PORT_ADDR_DEFAULT,
  parameter int unsigned           StallTimeout = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    s_cpuif_req,
  input  logic                    s_cpuif_req_is_wr,
  input  logic [CsrAddrWidth-1:0] s_cpuif_addr,
  input  logic [CsrDataWidth-1:0] s_cpuif_wr_data,
  input  logic [CsrDataWidth-1:0] s_cpuif_wr_biten,
  output logic                    s_cpuif_req_stall_wr,
  output logic                    s_cpuif_req_stall_rd,
  output logic                    s_cpuif_rd_ack,
  output logic                    s_cpuif_rd_err,
  output logic [CsrDataWidth-1:0] s_cpuif_rd_data,
  output logic                    s_cpuif_wr_ack,
  output logic                    s_cpuif_wr_err,
  output logic                    csr_req,
  output logic                    csr_req_is_wr,
  output logic [CsrAddrWidth-1:0] csr_addr,
  output logic [CsrDataWidth-1:0] csr_wr_data,
  output logic [CsrDataWidth-1:0] csr_wr_biten,
  input  logic                    csr_req_stall_wr,
  input  logic                    csr_req_stall_rd,
  input  logic                    csr_rd_ack,
  input  logic                    csr_rd_err,
  input  logic [CsrDataWidth-1:0] csr_rd_data,
  input  logic                    csr_wr_ack,
  input  logic                    csr_wr_err,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [CsrDataWidth-1:0] tx_data_o,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [CsrDataWidth-1:0] rx_data_i,
  output state_t                  dbg_state_o
);

  state_t state_q;
  resp_t  rd_resp_q;
  logic   wr_ack_q, wr_err_q;
  logic   win_tx, win_rx, in_wait, tmo;

  assign win_tx  = (s_cpuif_addr == TxPortAddr);
  assign win_rx  = (s_cpuif_addr == RxPortAddr);
  assign in_wait = (state_q == TX_WAIT) || (state_q == RX_WAIT);

  // Pass-through request path; window addresses never reach the CSR block.
  assign csr_req       = s_cpuif_req && !(win_tx || win_rx);
  assign csr_req_is_wr = s_cpuif_req_is_wr;
  assign csr_addr      = s_cpuif_addr;
  assign csr_wr_data   = s_cpuif_wr_data;
  assign csr_wr_biten  = s_cpuif_wr_biten;

  // Merge CSR block responses with window FSM responses.
  assign s_cpuif_req_stall_wr = csr_req_stall_wr || (state_q == TX_WAIT);
  assign s_cpuif_req_stall_rd = csr_req_stall_rd || (state_q == RX_WAIT);
  assign s_cpuif_rd_ack       = csr_rd_ack || rd_resp_q.ack;
  assign s_cpuif_rd_err       = csr_rd_err || rd_resp_q.err;
  assign s_cpuif_rd_data      = rd_resp_q.ack ? rd_resp_q.data : csr_rd_data;
  assign s_cpuif_wr_ack       = csr_wr_ack || wr_ack_q;
  assign s_cpuif_wr_err       = csr_wr_err || wr_err_q;

  assign rx_ready_o  = (state_q == RX_WAIT);
  assign dbg_state_o = state_q;

  wait_timer #(.StallTimeout(StallTimeout)) u_wait_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (!in_wait),
    .en_i   (in_wait),
    .tc_o   (tmo)
  );

  // Window FSM: decode, queue handshake with timeout, one-cycle response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      rd_resp_q  <= '0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_resp_q <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_cpuif_req && s_cpuif_req_is_wr && win_tx) begin
            if (&s_cpuif_wr_biten) begin
              tx_data_o  <= s_cpuif_wr_data;
              tx_valid_o <= 1'b1;
              state_q    <= TX_WAIT;
            end else begin
              wr_ack_q <= 1'b1;
              wr_err_q <= 1'b1;
              state_q  <= WR_RESP;
            end
          end else if (s_cpuif_req && !s_cpuif_req_is_wr && win_rx) begin
            state_q <= RX_WAIT;
          end else if (s_cpuif_req && !s_cpuif_req_is_wr && win_tx) begin
            rd_resp_q <= '{ack: 1'b1, err: 1'b1, data: '0};
            state_q   <= RD_RESP;
          end else if (s_cpuif_req && s_cpuif_req_is_wr && win_rx) begin
            wr_ack_q <= 1'b1;
            wr_err_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        TX_WAIT: begin
          // A handshake on the timeout cycle still completes cleanly.
          if (tx_ready_i || tmo) begin
            tx_valid_o <= 1'b0;
            wr_ack_q   <= 1'b1;
            wr_err_q   <= !tx_ready_i;
            state_q    <= WR_RESP;
          end
        end
        RX_WAIT: begin
          if (rx_valid_i) begin
            rd_resp_q <= '{ack: 1'b1, err: 1'b0, data: rx_data_i};
            state_q   <= RD_RESP;
          end else if (tmo) begin
            rd_resp_q <= '{ack: 1'b1, err: 1'b1, data: '0};
            state_q   <= RD_RESP;
          end
        end
        WR_RESP, RD_RESP: state_q <= IDLE;
        default:          state_q <= IDLE;
      endcase
    end
  end

  // Protocol checks: no new access while busy, no response collisions.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(s_cpuif_req && (state_q != IDLE)))
        else $error("csr_fifo_window: request while window busy");
      assert (!((rd_resp_q.ack || wr_ack_q) && (csr_rd_ack || csr_wr_ack)))
        else $error("csr_fifo_window: window ack collides with csr ack");
    end
  end

endmodule

// File: tb/tb_csr_fifo_window.sv
// Directed bench for csr_fifo_window: data-port push/pop, stall, timeout,
// error responses, pass-through and mid-transfer reset.
module tb_csr_fifo_window;
  import csr_fifo_window_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_cpuif_req = 1'b0, s_cpuif_req_is_wr = 1'b0;
  logic [11:0] s_cpuif_addr = '0;
  logic [31:0] s_cpuif_wr_data = '0, s_cpuif_wr_biten = '0;
  logic        s_cpuif_req_stall_wr, s_cpuif_req_stall_rd;
  logic        s_cpuif_rd_ack, s_cpuif_rd_err;
  logic [31:0] s_cpuif_rd_data;
  logic        s_cpuif_wr_ack, s_cpuif_wr_err;
  logic        csr_req, csr_req_is_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wr_data, csr_wr_biten;
  logic        csr_req_stall_wr = 1'b0, csr_req_stall_rd = 1'b0;
  logic        csr_rd_ack = 1'b0, csr_rd_err = 1'b0;
  logic [31:0] csr_rd_data = 32'hA5A5_A5A5;
  logic        csr_wr_ack = 1'b0, csr_wr_err = 1'b0;
  logic        tx_valid_o, tx_ready_i = 1'b0;
  logic [31:0] tx_data_o;
  logic        rx_valid_i = 1'b0, rx_ready_o;
  logic [31:0] rx_data_i = '0;
  state_t      dbg_state_o;

  int errors = 0;
  int checks = 0;
  int seen_ack;

  csr_fifo_window #(.StallTimeout(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_cpuif_req(s_cpuif_req), .s_cpuif_req_is_wr(s_cpuif_req_is_wr),
    .s_cpuif_addr(s_cpuif_addr), .s_cpuif_wr_data(s_cpuif_wr_data),
    .s_cpuif_wr_biten(s_cpuif_wr_biten),
    .s_cpuif_req_stall_wr(s_cpuif_req_stall_wr), .s_cpuif_req_stall_rd(s_cpuif_req_stall_rd),
    .s_cpuif_rd_ack(s_cpuif_rd_ack), .s_cpuif_rd_err(s_cpuif_rd_err),
    .s_cpuif_rd_data(s_cpuif_rd_data),
    .s_cpuif_wr_ack(s_cpuif_wr_ack), .s_cpuif_wr_err(s_cpuif_wr_err),
    .csr_req(csr_req), .csr_req_is_wr(csr_req_is_wr), .csr_addr(csr_addr),
    .csr_wr_data(csr_wr_data), .csr_wr_biten(csr_wr_biten),
    .csr_req_stall_wr(csr_req_stall_wr), .csr_req_stall_rd(csr_req_stall_rd),
    .csr_rd_ack(csr_rd_ack), .csr_rd_err(csr_rd_err), .csr_rd_data(csr_rd_data),
    .csr_wr_ack(csr_wr_ack), .csr_wr_err(csr_wr_err),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Driver: present a one-cycle access (the caller ticks).
  task automatic drive_req(input logic wr, input logic [11:0] addr,
                           input logic [31:0] data, input logic [31:0] biten);
    s_cpuif_req       = 1'b1;
    s_cpuif_req_is_wr = wr;
    s_cpuif_addr      = addr;
    s_cpuif_wr_data   = data;
    s_cpuif_wr_biten  = biten;
  endtask

  task automatic drop_req();
    s_cpuif_req = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    check("rst_wr_ack", 32'(s_cpuif_wr_ack), 32'd0);
    check("rst_rd_data", s_cpuif_rd_data, 32'hA5A5_A5A5);
    check("rst_tx_data", tx_data_o, 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(IDLE));
    rst_ni = 1'b1;
    tick();

    // TX push, queue ready: push at cycle 1, ack at cycle 2
    tx_ready_i = 1'b1;
    drive_req(1'b1, 12'h0C8, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    #1 check("tx_csr_req_blocked", 32'(csr_req), 32'd0);
    tick(); drop_req();
    check("tx_valid_c1", 32'(tx_valid_o), 32'd1);
    check("tx_data_c1", tx_data_o, 32'hDEAD_BEEF);
    check("tx_stall_c1", 32'(s_cpuif_req_stall_wr), 32'd1);
    check("tx_noack_c1", 32'(s_cpuif_wr_ack), 32'd0);
    tick();
    check("tx_valid_c2", 32'(tx_valid_o), 32'd0);
    check("tx_ack_c2", 32'(s_cpuif_wr_ack), 32'd1);
    check("tx_err_c2", 32'(s_cpuif_wr_err), 32'd0);
    check("tx_stall_c2", 32'(s_cpuif_req_stall_wr), 32'd0);
    tick();
    check("tx_ack_c3", 32'(s_cpuif_wr_ack), 32'd0);
    check("tx_idle", 32'(dbg_state_o), 32'(IDLE));
    tx_ready_i = 1'b0;

    // RX pop after 10 idle cycles
    drive_req(1'b0, 12'h0CC, 32'd0, 32'd0);
    tick(); drop_req();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rx_stall_%0d", i), 32'(s_cpuif_req_stall_rd), 32'd1);
      check($sformatf("rx_ready_%0d", i), 32'(rx_ready_o), 32'd1);
      check($sformatf("rx_noack_%0d", i), 32'(s_cpuif_rd_ack), 32'd0);
      tick();
    end
    rx_valid_i = 1'b1;
    rx_data_i  = 32'h1234_5678;
    check("rx_stall_hs", 32'(s_cpuif_req_stall_rd), 32'd1);
    tick();
    rx_valid_i = 1'b0;
    rx_data_i  = 32'hFFFF_0000;
    check("rx_ack", 32'(s_cpuif_rd_ack), 32'd1);
    check("rx_err", 32'(s_cpuif_rd_err), 32'd0);
    check("rx_data", s_cpuif_rd_data, 32'h1234_5678);
    check("rx_ready_done", 32'(rx_ready_o), 32'd0);
    check("rx_stall_done", 32'(s_cpuif_req_stall_rd), 32'd0);
    tick();
    check("rx_ack_gone", 32'(s_cpuif_rd_ack), 32'd0);

    // TX timeout: valid held for TMO cycles, then error ack
    drive_req(1'b1, 12'h0C8, 32'h0BAD_CAFE, 32'hFFFF_FFFF);
    tick(); drop_req();
    for (int i = 0; i < int'(TMO); i++) begin
      check($sformatf("tmo_valid_%0d", i), 32'(tx_valid_o), 32'd1);
      check($sformatf("tmo_noack_%0d", i), 32'(s_cpuif_wr_ack), 32'd0);
      tick();
    end
    check("tmo_valid_drop", 32'(tx_valid_o), 32'd0);
    check("tmo_ack", 32'(s_cpuif_wr_ack), 32'd1);
    check("tmo_err", 32'(s_cpuif_wr_err), 32'd1);
    tick();
    check("tmo_idle", 32'(dbg_state_o), 32'(IDLE));

    // Handshake on the timeout cycle wins
    drive_req(1'b1, 12'h0C8, 32'h5555_AAAA, 32'hFFFF_FFFF);
    tick(); drop_req();
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    check("edge_valid_last", 32'(tx_valid_o), 32'd1);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    check("edge_ack", 32'(s_cpuif_wr_ack), 32'd1);
    check("edge_err", 32'(s_cpuif_wr_err), 32'd0);
    tick();

    // RX timeout returns error with zero data
    drive_req(1'b0, 12'h0CC, 32'd0, 32'd0);
    tick(); drop_req();
    for (int i = 0; i < int'(TMO); i++) tick();
    check("rxtmo_ack", 32'(s_cpuif_rd_ack), 32'd1);
    check("rxtmo_err", 32'(s_cpuif_rd_err), 32'd1);
    check("rxtmo_data", s_cpuif_rd_data, 32'd0);
    tick();

    // Partial byte enables on TX: error, no push
    drive_req(1'b1, 12'h0C8, 32'h1111_2222, 32'h0000_FFFF);
    tick(); drop_req();
    check("part_ack", 32'(s_cpuif_wr_ack), 32'd1);
    check("part_err", 32'(s_cpuif_wr_err), 32'd1);
    check("part_novalid", 32'(tx_valid_o), 32'd0);
    tick();

    // Wrong-direction accesses
    drive_req(1'b0, 12'h0C8, 32'd0, 32'd0);
    tick(); drop_req();
    check("rdtx_ack", 32'(s_cpuif_rd_ack), 32'd1);
    check("rdtx_err", 32'(s_cpuif_rd_err), 32'd1);
    check("rdtx_data", s_cpuif_rd_data, 32'd0);
    tick();
    drive_req(1'b1, 12'h0CC, 32'h7777_7777, 32'hFFFF_FFFF);
    tick(); drop_req();
    check("wrrx_ack", 32'(s_cpuif_wr_ack), 32'd1);
    check("wrrx_err", 32'(s_cpuif_wr_err), 32'd1);
    check("wrrx_norx", 32'(rx_ready_o), 32'd0);
    tick();

    // Pass-through read to 0x010
    drive_req(1'b0, 12'h010, 32'h0, 32'h0);
    #1;
    check("pt_csr_req", 32'(csr_req), 32'd1);
    check("pt_csr_addr", 32'(csr_addr), 32'h010);
    check("pt_csr_is_wr", 32'(csr_req_is_wr), 32'd0);
    tick(); drop_req();
    csr_rd_ack = 1'b1; csr_rd_data = 32'hCAFE_F00D; csr_req_stall_rd = 1'b1;
    #1;
    check("pt_rd_ack", 32'(s_cpuif_rd_ack), 32'd1);
    check("pt_rd_data", s_cpuif_rd_data, 32'hCAFE_F00D);
    check("pt_stall_rd", 32'(s_cpuif_req_stall_rd), 32'd1);
    check("pt_no_tx", 32'(tx_valid_o), 32'd0);
    check("pt_no_rx", 32'(rx_ready_o), 32'd0);
    tick();
    csr_rd_ack = 1'b0; csr_rd_data = 32'hA5A5_A5A5; csr_req_stall_rd = 1'b0;
    // Pass-through write
    drive_req(1'b1, 12'h010, 32'h89AB_CDEF, 32'h00FF_00FF);
    #1;
    check("ptw_csr_req", 32'(csr_req), 32'd1);
    check("ptw_wr_data", csr_wr_data, 32'h89AB_CDEF);
    check("ptw_biten", csr_wr_biten, 32'h00FF_00FF);
    tick(); drop_req();
    csr_wr_ack = 1'b1; csr_wr_err = 1'b1;
    #1;
    check("ptw_ack", 32'(s_cpuif_wr_ack), 32'd1);
    check("ptw_err", 32'(s_cpuif_wr_err), 32'd1);
    tick();
    csr_wr_ack = 1'b0; csr_wr_err = 1'b0;

    // Reset during TX_WAIT: valid drops at once, no ack afterwards
    drive_req(1'b1, 12'h0C8, 32'hFEED_0001, 32'hFFFF_FFFF);
    tick(); drop_req();
    check("rstw_valid_pre", 32'(tx_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1 check("rstw_valid_async", 32'(tx_valid_o), 32'd0);
    tick(); tick();
    #2 rst_ni = 1'b1;
    seen_ack = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_cpuif_wr_ack) seen_ack++;
    end
    check("rstw_no_ack", 32'(seen_ack), 32'd0);
    check("rstw_idle", 32'(dbg_state_o), 32'(IDLE));
    tx_ready_i = 1'b1;
    drive_req(1'b1, 12'h0C8, 32'hFEED_0002, 32'hFFFF_FFFF);
    tick(); drop_req();
    check("rstw_next_data", tx_data_o, 32'hFEED_0002);
    tick();
    check("rstw_next_ack", 32'(s_cpuif_wr_ack), 32'd1);
    check("rstw_next_err", 32'(s_cpuif_wr_err), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the whole run in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_fifo_window.md
Name: csr_fifo_window

Overview:
- Sits directly downstream of the AXI-to-CSR adapter, on its s_cpuif_* CSR access interface.
- Decodes two data-port addresses, TX_DATA_PORT and RX_DATA_PORT, and turns accesses to them into valid/ready push/pop transfers on external queues.
- Stalls the CPU access until the queue side handshakes; a bounded timeout stops a hung queue from locking the bus.
- All other addresses pass through unchanged to the generated CSR block.

Parameters:
- CsrAddrWidth, 12, CPU-interface address width.
- CsrDataWidth, 32, CPU-interface and queue data width.
- TxPortAddr, 12'h0C8, byte address of the TX data port (write-only).
- RxPortAddr, 12'h0CC, byte address of the RX data port (read-only).
- StallTimeout, 256, maximum cycles spent waiting for a queue handshake; must be >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_cpuif_req, s_cpuif_req_is_wr  in  1 each  access strobe (one cycle per access) and direction
- s_cpuif_addr  in  CsrAddrWidth  byte address
- s_cpuif_wr_data, s_cpuif_wr_biten  in  CsrDataWidth each  write data and bit enables
- s_cpuif_req_stall_wr, s_cpuif_req_stall_rd  out  1 each  hold request toward the adapter
- s_cpuif_rd_ack, s_cpuif_rd_err  out  1 each  read completion and read error
- s_cpuif_rd_data  out  CsrDataWidth  read data
- s_cpuif_wr_ack, s_cpuif_wr_err  out  1 each  write completion and write error
- csr_req, csr_req_is_wr, csr_addr, csr_wr_data, csr_wr_biten  out  as upstream  pass-through request to the CSR block
- csr_req_stall_wr, csr_req_stall_rd, csr_rd_ack, csr_rd_err, csr_rd_data, csr_wr_ack, csr_wr_err  in  as upstream  CSR block responses
- tx_valid_o  out  1  TX push valid
- tx_ready_i  in  1  TX push ready
- tx_data_o  out  CsrDataWidth  TX push data
- rx_valid_i  in  1  RX pop valid
- rx_ready_o  out  1  RX pop ready
- rx_data_i  in  CsrDataWidth  RX pop data

Behaviour:
- Reset: every output is 0 and the FSM is IDLE. Asynchronous assertion mid-transfer drops tx_valid_o/rx_ready_o immediately; the in-flight access is discarded with no ack.
- Decode: win_tx = (addr == TxPortAddr); win_rx = (addr == RxPortAddr); the comparison covers all address bits.
- Pass-through when not win_tx/win_rx: csr_req = s_cpuif_req; other csr_* request fields are wired from the s_cpuif_* inputs.
  - For window addresses, csr_req = 0.
  - Upstream stalls = csr stall OR FSM stall; upstream acks/errs = csr OR FSM.
  - s_cpuif_rd_data = fsm_rd_ack ? fsm_rd_data : csr_rd_data.
- FSM states: IDLE, TX_WAIT, RX_WAIT, WR_RESP, RD_RESP.
- IDLE, valid TX write (req & is_wr & win_tx & biten all-ones): register data into tx_data_o, set tx_valid_o, go to TX_WAIT.
- IDLE, TX write with partial biten: go to WR_RESP with error; no push.
- IDLE, RX read (req & !is_wr & win_rx): go to RX_WAIT.
- IDLE, wrong-direction window access (read of TX, write of RX): go to the matching RESP state with error; rd_data = 0.
- TX_WAIT:
  - s_cpuif_req_stall_wr = 1.
  - tx_valid_o and tx_data_o are held stable until tx_valid_o & tx_ready_i. On that cycle tx_valid_o clears next edge and the FSM goes to WR_RESP (ok).
  - Minimum latency is req at cycle 0, push at cycle 1, wr_ack at cycle 2.
- RX_WAIT:
  - s_cpuif_req_stall_rd = 1 and rx_ready_o = 1.
  - On rx_valid_i, capture rx_data_i and go to RD_RESP (ok).
  - Minimum latency is req at cycle 0, pop at cycle 1, rd_ack with data at cycle 2.
- WR_RESP / RD_RESP: pulse the ack (with err if flagged, data on reads) for exactly 1 cycle; stall is 0; return to IDLE.
- Timeout:
  - A counter clears on entry to either WAIT state and increments each WAIT cycle.
  - At count == StallTimeout-1 with no handshake: drop tx_valid_o/rx_ready_o, go to RESP with err, rd_data = 0.
  - A handshake on the same cycle as the timeout wins (no error).
- Any s_cpuif_req arriving while the FSM is not IDLE is ignored. An assertion flags it, and also flags fsm ack coinciding with any csr ack.

Decomposition:
- Package csr_fifo_window_pkg holds the state enum, the response-flag struct {ack, err, data}, and the default port address constants.
- One sub-module, wait_timer: a counter with clear/enable, terminal-count output and a StallTimeout parameter.

Test Plan:
- Write 32'hDEAD_BEEF to 0x0C8 with tx_ready_i = 1 → tx_valid_o high 1 cycle with that data, then wr_ack = 1, wr_err = 0 two cycles after req.
- Read 0x0CC with rx_valid_i held low 10 cycles, then rx_data_i = 32'h1234_5678 → stall_rd high 10 cycles, then rd_ack with 32'h1234_5678.
- StallTimeout = 16, TX write with tx_ready_i = 0 → tx_valid_o drops at cycle 16; wr_ack = wr_err = 1; FSM returns to IDLE.
- Write to 0x0C8 with biten = 32'h0000_FFFF → wr_ack + wr_err, no tx_valid_o. Read of 0x0C8 → rd_ack + rd_err, data 0.
- Access to 0x010 → csr_req mirrors; csr_rd_ack/data returned unchanged; tx_valid_o/rx_ready_o stay 0.
- rst_ni asserted mid TX_WAIT → tx_valid_o = 0 asynchronously; no ack after release; next access completes normally.
